// File: rtl/clock_meter_pkg.sv
// Shared constants for the clock period meter: FSM state encoding and the
// default counter width.
package clock_meter_pkg;

  localparam int unsigned DEFAULT_CNT_WIDTH = 28;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_MEASURE = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with history flop and rise/fall decode. The *_next
// outputs show what level/rise/fall will be one cycle ahead, for consumers
// that must register a result aligned with the rise/fall strobes.
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic level_next,
  output logic rise_next,
  output logic fall_next
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level      = s2_q;
  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;
  assign level_next = s1_q;
  assign rise_next  = s1_q & ~s2_q;
  assign fall_next  = ~s1_q & s2_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow square wave in clk_in cycles, with
// lock/timeout monitoring and one-cycle rise/fall strobes.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned           CNT_WIDTH      = DEFAULT_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0]  TIMEOUT_CYCLES = 28'd10000000
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 sig_in,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic level, rise, fall, level_next, rise_next, fall_next;

  sync_edge_detect u_sync (
    .clk_in     (clk_in),
    .rst        (rst),
    .sig_in     (sig_in),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .level_next (level_next),
    .rise_next  (rise_next),
    .fall_next  (fall_next)
  );

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                 fall_seen_q, fall_seen_d;
  logic                 primed_q, primed_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;

  // The FSM acts on the look-ahead edges so that registered meas_valid/period
  // land in the same cycle as the rise_pulse that closes the period.
  // primed_q blocks the first post-reset cycle, where the synchronizer still
  // holds its reset zeros and a high input would look like a fresh low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_cnt_d     = hi_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    fall_seen_d  = fall_seen_q;
    primed_d     = 1'b1;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;

    if (meas_valid_q) begin
      locked_d = 1'b1;
    end else if (timeout_q) begin
      locked_d = 1'b0;
    end else begin
      locked_d = locked_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (primed_q && !level_next && !level) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (rise_next) begin
          cnt_d       = CNT_ONE;
          fall_seen_d = 1'b0;
          state_d     = ST_MEASURE;
        end else begin
          state_d     = ST_ARMED;
        end
      end
      ST_MEASURE: begin
        if (rise_next) begin
          period_d     = cnt_q;
          high_time_d  = hi_cnt_q;
          meas_valid_d = 1'b1;
          cnt_d        = CNT_ONE;
          fall_seen_d  = 1'b0;
        end else if (cnt_q == TIMEOUT_CYCLES) begin
          timeout_d    = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall_next && !fall_seen_q) begin
            hi_cnt_d    = cnt_q;
            fall_seen_d = 1'b1;
          end else begin
            fall_seen_d = fall_seen_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_cnt_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      fall_seen_q  <= 1'b0;
      primed_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      fall_seen_q  <= fall_seen_d;
      primed_q     <= primed_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  assign rise_pulse = rise;
  assign fall_pulse = fall;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
